// File: rtl/sha256_padder.sv
// -----------------------------------------------------------------------------
// sha256_padder
//
// Message front end for the SHA-256 core. Collects a host message as a
// stream of 32-bit words, assembles 512-bit blocks, appends the SHA-256
// padding (0x80 marker, zero fill, 64-bit big-endian bit length) and hands
// each finished block to the core once the core is idle.
//
// Parameters
//   HOLDOFF      cycles after each oBlockValid before iCoreBusy is trusted
//                again (covers the core's busy-rise latency)
//
// Ports
//   iClk         clock, rising edge
//   iReset       asynchronous active-high reset
//   iWord        message word, first byte in [31:24]
//   iWordValid   iWord is presented
//   iLast        presented word is the final word of the message
//   iByteCnt     valid bytes in the final word (0..4, larger means 4)
//   oReady       padder accepts a word this cycle
//   iCoreBusy    busy output of the SHA-256 core
//   oBlock       assembled block, word 0 in [511:480]
//   oBlockValid  one-cycle pulse, oBlock valid
//   oFirstBlock  with oBlockValid on the first block of a message
//   oMsgDone     with oBlockValid on the final padded block
//
// Configuration macro
//   SHA256_PADDER_BYTESWAP_EN  byte-reverse iWord on input (little-endian
//                              hosts, first byte in [7:0])
// -----------------------------------------------------------------------------
module sha256_padder #(
    parameter int HOLDOFF = 2
) (
    input  logic         iClk,
    input  logic         iReset,
    input  logic [31:0]  iWord,
    input  logic         iWordValid,
    input  logic         iLast,
    input  logic [2:0]   iByteCnt,
    output logic         oReady,
    input  logic         iCoreBusy,
    output logic [511:0] oBlock,
    output logic         oBlockValid,
    output logic         oFirstBlock,
    output logic         oMsgDone
);

    typedef enum logic [1:0] {FILL, PAD, LEN, SEND} state_t;
    typedef enum logic [1:0] {RET_FILL, RET_PAD, RET_DONE} ret_t;

    localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    logic [31:0]   blk_buf [16];
    state_t        state;
    ret_t          ret_target;
    logic [4:0]    idx;
    logic [4:0]    idx_inc;
    logic [63:0]   len;
    logic          first;
    logic          need80;
    logic [HW-1:0] holdoff;

    logic [31:0]   word_in;
    logic [2:0]    byte_cnt;
    logic [31:0]   last_word;

`ifdef SHA256_PADDER_BYTESWAP_EN
    assign word_in = {iWord[7:0], iWord[15:8], iWord[23:16], iWord[31:24]};
`else
    assign word_in = iWord;
`endif

    assign idx_inc = idx + 5'd1;
    assign oReady  = (state == FILL);

    // Final word: keep the first byte_cnt bytes and, if there is room,
    // drop the 0x80 marker into the byte right after the message.
    always_comb begin
        byte_cnt  = (iByteCnt > 3'd4) ? 3'd4 : iByteCnt;
        last_word = word_in;
        case (byte_cnt)
            3'd0:    last_word = 32'h8000_0000;
            3'd1:    last_word = {word_in[31:24], 24'h80_0000};
            3'd2:    last_word = {word_in[31:16], 16'h8000};
            3'd3:    last_word = {word_in[31:8], 8'h80};
            default: last_word = word_in;
        endcase
    end

    // The buffer itself is the output; it persists until overwritten.
    for (genvar k = 0; k < 16; k++) begin : g_pack
        assign oBlock[511-32*k -: 32] = blk_buf[k];
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state       <= FILL;
            ret_target  <= RET_FILL;
            idx         <= '0;
            len         <= '0;
            first       <= 1'b1;
            need80      <= 1'b0;
            holdoff     <= '0;
            oBlockValid <= 1'b0;
            oFirstBlock <= 1'b0;
            oMsgDone    <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                blk_buf[k] <= '0;
            end
        end else begin
            oBlockValid <= 1'b0;
            oFirstBlock <= 1'b0;
            oMsgDone    <= 1'b0;
            if (holdoff != '0) begin
                holdoff <= holdoff - HW'(1);
            end

            case (state)
                FILL: begin
                    if (iWordValid) begin
                        idx <= idx_inc;
                        if (!iLast) begin
                            blk_buf[idx[3:0]] <= word_in;
                            len               <= len + 64'd32;
                            if (idx_inc == 5'd16) begin
                                state      <= SEND;
                                ret_target <= RET_FILL;
                            end
                        end else begin
                            blk_buf[idx[3:0]] <= last_word;
                            len               <= len + {58'd0, byte_cnt, 3'b000};
                            need80            <= (byte_cnt == 3'd4);
                            // Marker already placed and word 13 was the
                            // last one before the length: no padding needed.
                            if (byte_cnt != 3'd4 && idx_inc == 5'd14) begin
                                state <= LEN;
                            end else begin
                                state <= PAD;
                            end
                        end
                    end
                end

                PAD: begin
                    if (idx[4]) begin
                        state      <= SEND;
                        ret_target <= RET_PAD;
                    end else begin
                        blk_buf[idx[3:0]] <= need80 ? 32'h8000_0000 : 32'h0;
                        need80            <= 1'b0;
                        idx               <= idx_inc;
                        // Length did not fit: flush this block, pad on
                        // into a fresh one afterwards.
                        if (idx_inc == 5'd16) begin
                            state      <= SEND;
                            ret_target <= RET_PAD;
                        end else if (idx_inc == 5'd14) begin
                            state <= LEN;
                        end
                    end
                end

                LEN: begin
                    if (!idx[0]) begin
                        blk_buf[14] <= len[63:32];
                        idx         <= 5'd15;
                    end else begin
                        blk_buf[15] <= len[31:0];
                        idx         <= 5'd16;
                        state       <= SEND;
                        ret_target  <= RET_DONE;
                    end
                end

                SEND: begin
                    if (holdoff == '0 && !iCoreBusy) begin
                        oBlockValid <= 1'b1;
                        oFirstBlock <= first;
                        first       <= 1'b0;
                        holdoff     <= HW'(HOLDOFF);
                        idx         <= '0;
                        case (ret_target)
                            RET_FILL: state <= FILL;
                            RET_PAD:  state <= PAD;
                            default: begin
                                oMsgDone <= 1'b1;
                                len      <= '0;
                                first    <= 1'b1;
                                state    <= FILL;
                            end
                        endcase
                    end
                end

                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// -----------------------------------------------------------------------------
// tb_sha256_padder
//
// Directed self-checking bench for sha256_padder (default build, no byte
// swap). Expected blocks are hand-computed SHA-256 padded messages.
// -----------------------------------------------------------------------------
module tb_sha256_padder;

    logic         iClk = 1'b0;
    logic         iReset;
    logic [31:0]  iWord;
    logic         iWordValid;
    logic         iLast;
    logic [2:0]   iByteCnt;
    logic         oReady;
    logic         iCoreBusy;
    logic [511:0] oBlock;
    logic         oBlockValid;
    logic         oFirstBlock;
    logic         oMsgDone;

    int checks = 0;
    int errors = 0;

    logic [511:0] capBlk;
    logic         capFirst;
    logic         capDone;
    logic         got;
    int           lat;
    int           readyLeaks;
    int           validLeaks;
    logic [511:0] expBlk;
    logic [511:0] abcBlk;

    sha256_padder #(.HOLDOFF(2)) dut (
        .iClk        (iClk),
        .iReset      (iReset),
        .iWord       (iWord),
        .iWordValid  (iWordValid),
        .iLast       (iLast),
        .iByteCnt    (iByteCnt),
        .oReady      (oReady),
        .iCoreBusy   (iCoreBusy),
        .oBlock      (oBlock),
        .oBlockValid (oBlockValid),
        .oFirstBlock (oFirstBlock),
        .oMsgDone    (oMsgDone)
    );

    always #5 iClk = ~iClk;

    function automatic logic [511:0] putWord(input logic [511:0] b, input int k,
                                             input logic [31:0] w);
        logic [511:0] r;
        r = b;
        r[511-32*k -: 32] = w;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One word transfer; inputs change on the falling edge.
    task automatic applyStimulus(input logic [31:0] w, input logic last,
                                 input logic [2:0] n);
        @(negedge iClk);
        iWord      = w;
        iWordValid = 1'b1;
        iLast      = last;
        iByteCnt   = n;
        @(posedge iClk);
        #1;
        iWordValid = 1'b0;
        iLast      = 1'b0;
        iByteCnt   = 3'd0;
        iWord      = 32'h0;
    endtask

    // Waits (bounded) for the next oBlockValid, sampling on falling edges.
    task automatic waitBlock(input int budget);
        got        = 1'b0;
        lat        = 0;
        readyLeaks = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge iClk);
            if (oBlockValid) begin
                got      = 1'b1;
                lat      = i;
                capBlk   = oBlock;
                capFirst = oFirstBlock;
                capDone  = oMsgDone;
                break;
            end
            if (oReady) readyLeaks++;
        end
        checkOutput("block_arrived", 512'(got), 512'(1));
    endtask

    initial begin
        iReset     = 1'b1;
        iWord      = 32'h0;
        iWordValid = 1'b0;
        iLast      = 1'b0;
        iByteCnt   = 3'd0;
        iCoreBusy  = 1'b0;

        abcBlk = '0;
        abcBlk = putWord(abcBlk, 0, 32'h6162_6380);
        abcBlk = putWord(abcBlk, 15, 32'h0000_0018);

        // Reset state
        repeat (3) @(negedge iClk);
        checkOutput("rst_ready", 512'(oReady), 512'(1));
        checkOutput("rst_valid", 512'(oBlockValid), 512'(0));
        checkOutput("rst_first", 512'(oFirstBlock), 512'(0));
        checkOutput("rst_done", 512'(oMsgDone), 512'(0));
        checkOutput("rst_block", oBlock, 512'(0));
        iReset = 1'b0;

        // "abc": one word, 3 bytes
        applyStimulus(32'h6162_6300, 1'b1, 3'd3);
        waitBlock(100);
        checkOutput("abc_latency", 512'(lat), 512'(17));
        checkOutput("abc_block", capBlk, abcBlk);
        checkOutput("abc_first", 512'(capFirst), 512'(1));
        checkOutput("abc_done", 512'(capDone), 512'(1));
        checkOutput("abc_ready_low", 512'(readyLeaks), 512'(0));
        @(negedge iClk);
        checkOutput("abc_pulse_width", 512'(oBlockValid), 512'(0));

        // Empty message: garbage in the word must be masked away
        applyStimulus(32'hDEAD_BEEF, 1'b1, 3'd0);
        waitBlock(100);
        expBlk = putWord('0, 0, 32'h8000_0000);
        checkOutput("empty_block", capBlk, expBlk);
        checkOutput("empty_first", 512'(capFirst), 512'(1));
        checkOutput("empty_done", 512'(capDone), 512'(1));

        // Byte count above 4 behaves as 4
        applyStimulus(32'hCAFE_F00D, 1'b1, 3'd7);
        waitBlock(100);
        expBlk = putWord('0, 0, 32'hCAFE_F00D);
        expBlk = putWord(expBlk, 1, 32'h8000_0000);
        expBlk = putWord(expBlk, 15, 32'h0000_0020);
        checkOutput("clamp_block", capBlk, expBlk);

        // 14 full words: marker in word 14, length spills to a second block
        expBlk = '0;
        for (int k = 0; k < 14; k++) begin
            applyStimulus(32'hA500_0000 + 32'(k), (k == 13), 3'd4);
            expBlk = putWord(expBlk, k, 32'hA500_0000 + 32'(k));
        end
        expBlk = putWord(expBlk, 14, 32'h8000_0000);
        waitBlock(100);
        checkOutput("w14_blk1", capBlk, expBlk);
        checkOutput("w14_blk1_first", 512'(capFirst), 512'(1));
        checkOutput("w14_blk1_done", 512'(capDone), 512'(0));
        waitBlock(100);
        expBlk = putWord('0, 15, 32'h0000_01C0);
        checkOutput("w14_blk2", capBlk, expBlk);
        checkOutput("w14_blk2_first", 512'(capFirst), 512'(0));
        checkOutput("w14_blk2_done", 512'(capDone), 512'(1));

        // 16 full words, then a zero-byte final word
        expBlk = '0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(32'h3C00_0100 + 32'(k), 1'b0, 3'd0);
            expBlk = putWord(expBlk, k, 32'h3C00_0100 + 32'(k));
        end
        waitBlock(20);
        checkOutput("w16_latency", 512'(lat), 512'(2));
        checkOutput("w16_blk1", capBlk, expBlk);
        checkOutput("w16_blk1_first", 512'(capFirst), 512'(1));
        checkOutput("w16_blk1_done", 512'(capDone), 512'(0));
        applyStimulus(32'h0, 1'b1, 3'd0);
        waitBlock(100);
        expBlk = putWord('0, 0, 32'h8000_0000);
        expBlk = putWord(expBlk, 15, 32'h0000_0200);
        checkOutput("w16_blk2", capBlk, expBlk);
        checkOutput("w16_blk2_first", 512'(capFirst), 512'(0));
        checkOutput("w16_blk2_done", 512'(capDone), 512'(1));

        // Backpressure: core busy well past the padder reaching SEND
        @(negedge iClk);
        iCoreBusy = 1'b1;
        applyStimulus(32'h6162_6300, 1'b1, 3'd3);
        validLeaks = 0;
        readyLeaks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge iClk);
            if (oBlockValid) validLeaks++;
            if (oReady) readyLeaks++;
        end
        checkOutput("bp_no_valid", 512'(validLeaks), 512'(0));
        checkOutput("bp_ready_low", 512'(readyLeaks), 512'(0));
        iCoreBusy = 1'b0;
        waitBlock(10);
        checkOutput("bp_latency", 512'(lat), 512'(1));
        checkOutput("bp_block", capBlk, abcBlk);
        checkOutput("bp_first", 512'(capFirst), 512'(1));

        // Reset in the middle of a message discards everything
        for (int k = 0; k < 5; k++) begin
            applyStimulus(32'h5555_0000 + 32'(k), 1'b0, 3'd0);
        end
        @(negedge iClk);
        iReset = 1'b1;
        @(negedge iClk);
        checkOutput("mid_rst_block", oBlock, 512'(0));
        checkOutput("mid_rst_ready", 512'(oReady), 512'(1));
        iReset = 1'b0;
        applyStimulus(32'h6162_6300, 1'b1, 3'd3);
        waitBlock(100);
        checkOutput("mid_rst_abc_block", capBlk, abcBlk);
        checkOutput("mid_rst_abc_first", 512'(capFirst), 512'(1));
        checkOutput("mid_rst_abc_done", 512'(capDone), 512'(1));

        repeat (2) @(negedge iClk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Message-side front end for the SHA-256 core. It accepts a host message as a stream of 32-bit words, assembles 512-bit blocks and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It then hands each block to the core's start/block/valid inputs, waiting for the core to go idle first. It sits directly upstream of `sha256_top` and replaces manual host-side padding and per-word block register writes.

## Interface
- `HOLDOFF`, default 2: cycles after each `oBlockValid` before `iCoreBusy` is sampled again. Covers the core's busy-rise latency.
- `iClk`  in  1: clock; all logic is on the rising edge.
- `iReset`  in  1: asynchronous, active-high reset.
- `iWord`  in  32: message word. The first byte is in [31:24].
- `iWordValid`  in  1: `iWord` is presented.
- `iLast`  in  1: the presented word is the final word of the message.
- `iByteCnt`  in  3: number of valid bytes in the last word, 0..4. Only used when `iLast`=1. Values above 4 are treated as 4.
- `oReady`  out  1: the padder accepts a word. Transfer happens when `iWordValid & oReady`.
- `iCoreBusy`  in  1: the core's `busy` output.
- `oBlock`  out  512: assembled block. Word 0 is in [511:480].
- `oBlockValid`  out  1: one-cycle pulse; `oBlock` is valid in this cycle. Drives `block_valid`.
- `oFirstBlock`  out  1: high together with `oBlockValid` on the first block of a message. Drives `start_block`.
- `oMsgDone`  out  1: one-cycle pulse, coincident with `oBlockValid` of the final padded block.

## Operation
- Internal state:
  - 16×32 block buffer.
  - 5-bit word index `idx` (0..16).
  - 64-bit bit-length counter `len`; wraps modulo 2^64.
  - `first` flag, set at reset and after each `oMsgDone`.
- States: `FILL`, `PAD`, `LEN`, `SEND`. On reset: `FILL`, `idx`=0, `len`=0, `first`=1.
- FILL
  - `oReady`=1.
  - On a non-last transfer: store the word at `idx`, then `idx`+1 and `len`+32.
  - When `idx` reaches 16, go to SEND with return target FILL.
  - On a last transfer with n=`iByteCnt`:
    - Store the word with bytes n..3 cleared.
    - If n<4, put 0x80 in byte n.
    - Add `len`+8n, then `idx`+1.
    - Set `need80` = (n==4). Go to PAD.
- PAD
  - One word written per cycle.
  - If `need80` is set, write 0x80000000 first and clear `need80`.
  - Otherwise write zero.
  - Exit when `idx`==14 and `need80`=0: go to LEN.
  - If `idx` reaches 15 or 16 before 14 is met (0x80 did not fit in words 0..13):
    - Zero-fill through 15.
    - Go to SEND with return target PAD.
    - After sending, `idx` restarts at 0.
- LEN
  - Write `len[63:32]` at word 14, then `len[31:0]` at word 15.
  - Go to SEND with return target DONE.
- SEND
  - Wait until the holdoff counter is 0 and `iCoreBusy`=0.
  - Then pulse `oBlockValid`. `oFirstBlock`=`first`, then clear `first`.
  - Load the holdoff counter with `HOLDOFF`. Set `idx`=0.
  - Go to the return target. For DONE: pulse `oMsgDone`, set `len`=0 and `first`=1, then go to FILL.
- `oBlock` holds its contents until the next block's first word is written. The buffer is cleared only by reset.
- `iWordValid` while `oReady`=0 has no effect.
- Reset mid-message discards all partial data. No pulse is generated.

## Timing
- Reset values:
  - `oReady`=1.
  - `oBlockValid`, `oFirstBlock`, `oMsgDone` = 0.
  - `oBlock`=0.
- `oBlockValid`, `oFirstBlock` and `oMsgDone` are registered.
- Full block: 16th word accepted in cycle N, SEND in N+1. If the core is idle, `oBlockValid` is high in N+2.
- Last word at `idx` i (n<4):
  - PAD takes 13−i cycles.
  - LEN takes 2 cycles.
  - Then SEND.
- Minimum gap between consecutive `oBlockValid` pulses is `HOLDOFF`+1 cycles.
- `oReady`=0 throughout PAD, LEN and SEND.

## Configuration
- `SHA256_PADDER_BYTESWAP_EN`
  - Defined: `iWord` is byte-reversed on input, for little-endian hosts. Byte 0 is taken from [7:0]. `iByteCnt` counts from [7:0] upward.
  - Undefined: words are used as presented, first byte in [31:24].

## Test plan
- "abc": single word 0x61626300, `iLast`=1, `iByteCnt`=3 → one block.
  - Word 0 = 0x61626380, words 1–14 = 0, word 15 = 0x00000018.
  - `oFirstBlock`=1, `oMsgDone`=1.
- Empty message: `iLast`=1, `iByteCnt`=0 → one block.
  - Word 0 = 0x80000000, all other words 0.
- 14 full words (56 bytes) → two blocks.
  - Block 1: data, then word 14 = 0x80000000, word 15 = 0.
  - Block 2: words 0–14 = 0, word 15 = 0x000001C0.
  - `oFirstBlock` on block 1 only; `oMsgDone` on block 2 only.
- 16 full words → data block, then a block with word 0 = 0x80000000 and word 15 = 0x00000200.
- Backpressure: hold `iCoreBusy`=1 for 20 cycles while in SEND.
  - No `oBlockValid` while busy.
  - Pulse 1 cycle after `iCoreBusy` falls.
  - `oReady` stays 0.
- Reset mid-message: assert `iReset` after 5 words, then send "abc".
  - Output matches the "abc" case.
  - `oFirstBlock`=1.
